// File: rtl/axi4_lite_master_pkg.sv
// rtl/axi4_lite_master_pkg.sv - shared constants and FSM encodings for the AXI4-Lite master
//
// Purpose: AXI response codes, the protection value the master drives, and
//          the state encodings of the write and read engines.
// Ports:   none (package).
package axi4_lite_master_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [1:0] {
    WR_IDLE      = 2'd0,
    WR_ADDR_DATA = 2'd1,
    WR_RESP      = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } rd_state_t;

endpackage

// File: rtl/axi4_lite_master.sv
// rtl/axi4_lite_master.sv - AXI4-Lite master bridge for single-shot user reads and writes
//
// Purpose: turns a rising edge on write_req / read_req into one AXI4-Lite
//          write (AW+W then B) or read (AR then R) transaction. The write and
//          read engines are independent and may run concurrently.
// Ports:
//   iCLK, iRST                      clock, asynchronous active-low reset
//   m_AW*, m_W*, m_B*               AXI4-Lite write address / data / response
//   m_AR*, m_R*                     AXI4-Lite read address / data
//   write_req/addr/data/strb        user write request (started on rising edge)
//   write_done, write_resp          one-cycle completion pulse, held response
//   read_req/addr                   user read request (started on rising edge)
//   read_data, read_done, read_resp one-cycle completion pulse, held data/response
module axi4_lite_master
  import axi4_lite_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  // write address channel
  input  logic                      m_AWREADY,
  output logic                      m_AWVALID,
  output logic [ADDR_WIDTH-1:0]     m_AWADDR,
  output logic [2:0]                m_AWPROT,
  // write data channel
  input  logic                      m_WREADY,
  output logic                      m_WVALID,
  output logic [DATA_WIDTH-1:0]     m_WDATA,
  output logic [DATA_WIDTH/8-1:0]   m_WSTRB,
  // write response channel
  input  logic                      m_BVALID,
  input  logic [1:0]                m_BRESP,
  output logic                      m_BREADY,
  // read address channel
  input  logic                      m_ARREADY,
  output logic                      m_ARVALID,
  output logic [ADDR_WIDTH-1:0]     m_ARADDR,
  output logic [2:0]                m_ARPROT,
  // read data channel
  input  logic                      m_RVALID,
  input  logic [1:0]                m_RRESP,
  input  logic [DATA_WIDTH-1:0]     m_RDATA,
  output logic                      m_RREADY,
  // user write side
  input  logic                      write_req,
  input  logic [ADDR_WIDTH-1:0]     write_addr,
  input  logic [DATA_WIDTH-1:0]     write_data,
  input  logic [DATA_WIDTH/8-1:0]   write_strb,
  output logic                      write_done,
  output logic [1:0]                write_resp,
  // user read side
  input  logic                      read_req,
  input  logic [ADDR_WIDTH-1:0]     read_addr,
  output logic [DATA_WIDTH-1:0]     read_data,
  output logic                      read_done,
  output logic [1:0]                read_resp
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  assign m_AWPROT = PROT_DEFAULT;
  assign m_ARPROT = PROT_DEFAULT;

  // ---------------------------------------------------------------- write engine
  wr_state_t               wr_state_q, wr_state_d;
  logic                    write_req_q;
  logic                    awvalid_d, wvalid_d, bready_d, write_done_d;
  logic [ADDR_WIDTH-1:0]   awaddr_d;
  logic [DATA_WIDTH-1:0]   wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_d;
  logic [1:0]              write_resp_d;

  always_comb begin
    wr_state_d   = wr_state_q;
    awvalid_d    = m_AWVALID;
    wvalid_d     = m_WVALID;
    bready_d     = m_BREADY;
    awaddr_d     = m_AWADDR;
    wdata_d      = m_WDATA;
    wstrb_d      = m_WSTRB;
    write_resp_d = write_resp;
    write_done_d = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        if (write_req && !write_req_q) begin
          awaddr_d   = write_addr;
          wdata_d    = write_data;
          wstrb_d    = write_strb;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          wr_state_d = WR_ADDR_DATA;
        end
      end
      WR_ADDR_DATA: begin
        // Each VALID falls independently after its own handshake; a VALID
        // that is already low marks that channel as accepted.
        if (m_AWVALID && m_AWREADY) awvalid_d = 1'b0;
        if (m_WVALID && m_WREADY)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d   = 1'b1;
          wr_state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_BVALID && m_BREADY) begin
          bready_d     = 1'b0;
          write_resp_d = m_BRESP;
          write_done_d = 1'b1;
          wr_state_d   = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      wr_state_q  <= WR_IDLE;
      write_req_q <= 1'b0;
      m_AWVALID   <= 1'b0;
      m_WVALID    <= 1'b0;
      m_BREADY    <= 1'b0;
      m_AWADDR    <= '0;
      m_WDATA     <= '0;
      m_WSTRB     <= '0;
      write_resp  <= '0;
      write_done  <= 1'b0;
    end else begin
      wr_state_q  <= wr_state_d;
      write_req_q <= write_req;
      m_AWVALID   <= awvalid_d;
      m_WVALID    <= wvalid_d;
      m_BREADY    <= bready_d;
      m_AWADDR    <= awaddr_d;
      m_WDATA     <= wdata_d;
      m_WSTRB     <= wstrb_d;
      write_resp  <= write_resp_d;
      write_done  <= write_done_d;
    end
  end

  // ----------------------------------------------------------------- read engine
  rd_state_t               rd_state_q, rd_state_d;
  logic                    read_req_q;
  logic                    arvalid_d, rready_d, read_done_d;
  logic [ADDR_WIDTH-1:0]   araddr_d;
  logic [DATA_WIDTH-1:0]   read_data_d;
  logic [1:0]              read_resp_d;

  always_comb begin
    rd_state_d  = rd_state_q;
    arvalid_d   = m_ARVALID;
    rready_d    = m_RREADY;
    araddr_d    = m_ARADDR;
    read_data_d = read_data;
    read_resp_d = read_resp;
    read_done_d = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if (read_req && !read_req_q) begin
          araddr_d   = read_addr;
          arvalid_d  = 1'b1;
          rd_state_d = RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (m_ARVALID && m_ARREADY) begin
          arvalid_d  = 1'b0;
          rready_d   = 1'b1;
          rd_state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (m_RVALID && m_RREADY) begin
          rready_d    = 1'b0;
          read_data_d = m_RDATA;
          read_resp_d = m_RRESP;
          read_done_d = 1'b1;
          rd_state_d  = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      rd_state_q <= RD_IDLE;
      read_req_q <= 1'b0;
      m_ARVALID  <= 1'b0;
      m_RREADY   <= 1'b0;
      m_ARADDR   <= '0;
      read_data  <= '0;
      read_resp  <= '0;
      read_done  <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      read_req_q <= read_req;
      m_ARVALID  <= arvalid_d;
      m_RREADY   <= rready_d;
      m_ARADDR   <= araddr_d;
      read_data  <= read_data_d;
      read_resp  <= read_resp_d;
      read_done  <= read_done_d;
    end
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
// tb/tb_axi4_lite_master.sv - directed self-checking bench for axi4_lite_master
module tb_axi4_lite_master;

  logic        iCLK;
  logic        iRST;
  logic        m_AWREADY, m_AWVALID;
  logic [31:0] m_AWADDR;
  logic [2:0]  m_AWPROT;
  logic        m_WREADY, m_WVALID;
  logic [31:0] m_WDATA;
  logic [3:0]  m_WSTRB;
  logic        m_BVALID, m_BREADY;
  logic [1:0]  m_BRESP;
  logic        m_ARREADY, m_ARVALID;
  logic [31:0] m_ARADDR;
  logic [2:0]  m_ARPROT;
  logic        m_RVALID, m_RREADY;
  logic [1:0]  m_RRESP;
  logic [31:0] m_RDATA;
  logic        write_req;
  logic [31:0] write_addr, write_data;
  logic [3:0]  write_strb;
  logic        write_done;
  logic [1:0]  write_resp;
  logic        read_req;
  logic [31:0] read_addr, read_data;
  logic        read_done;
  logic [1:0]  read_resp;

  int n_checks = 0;
  int n_fail   = 0;
  int ar_cnt   = 0;
  int aw_cnt   = 0;
  int wd_cnt   = 0;
  int rd_cnt   = 0;

  axi4_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .m_AWREADY(m_AWREADY), .m_AWVALID(m_AWVALID), .m_AWADDR(m_AWADDR), .m_AWPROT(m_AWPROT),
    .m_WREADY(m_WREADY), .m_WVALID(m_WVALID), .m_WDATA(m_WDATA), .m_WSTRB(m_WSTRB),
    .m_BVALID(m_BVALID), .m_BRESP(m_BRESP), .m_BREADY(m_BREADY),
    .m_ARREADY(m_ARREADY), .m_ARVALID(m_ARVALID), .m_ARADDR(m_ARADDR), .m_ARPROT(m_ARPROT),
    .m_RVALID(m_RVALID), .m_RRESP(m_RRESP), .m_RDATA(m_RDATA), .m_RREADY(m_RREADY),
    .write_req(write_req), .write_addr(write_addr), .write_data(write_data), .write_strb(write_strb),
    .write_done(write_done), .write_resp(write_resp),
    .read_req(read_req), .read_addr(read_addr),
    .read_data(read_data), .read_done(read_done), .read_resp(read_resp)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // handshake and completion counters, sampled mid-cycle
  always @(negedge iCLK) begin
    if (iRST) begin
      if (m_ARVALID && m_ARREADY) ar_cnt++;
      if (m_AWVALID && m_AWREADY) aw_cnt++;
      if (write_done) wd_cnt++;
      if (read_done)  rd_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    m_AWREADY = 0; m_WREADY = 0; m_BVALID = 0; m_BRESP = 0;
    m_ARREADY = 0; m_RVALID = 0; m_RRESP = 0; m_RDATA = 0;
  endtask

  // Write against an always-ready slave; checks the fixed latency path.
  task automatic write_fast(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] br, input string tag);
    @(posedge iCLK); #1;
    m_AWREADY = 1; m_WREADY = 1; m_BVALID = 1; m_BRESP = br;
    write_req = 1; write_addr = a; write_data = d; write_strb = s;
    @(negedge iCLK);
    check({tag, "_awv_pre"}, m_AWVALID, 0);
    @(posedge iCLK); #1;
    write_req = 0; write_addr = 32'hFFFF_FFFF; write_data = 0; write_strb = 0;
    @(negedge iCLK);
    check({tag, "_awv"}, m_AWVALID, 1);
    check({tag, "_wv"}, m_WVALID, 1);
    check({tag, "_awaddr"}, m_AWADDR, a);
    check({tag, "_wdata"}, m_WDATA, d);
    check({tag, "_wstrb"}, m_WSTRB, s);
    @(negedge iCLK);
    check({tag, "_awv_off"}, m_AWVALID, 0);
    check({tag, "_wv_off"}, m_WVALID, 0);
    check({tag, "_bready"}, m_BREADY, 1);
    @(negedge iCLK);
    check({tag, "_done"}, write_done, 1);
    check({tag, "_resp"}, write_resp, br);
    check({tag, "_bready_off"}, m_BREADY, 0);
    @(negedge iCLK);
    check({tag, "_done_off"}, write_done, 0);
    check({tag, "_resp_hold"}, write_resp, br);
    @(posedge iCLK); #1;
    slave_idle();
  endtask

  // Read against an always-ready slave.
  task automatic read_fast(input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] rr, input string tag);
    @(posedge iCLK); #1;
    m_ARREADY = 1; m_RVALID = 1; m_RDATA = d; m_RRESP = rr;
    read_req = 1; read_addr = a;
    @(posedge iCLK); #1;
    read_req = 0; read_addr = 32'h5555_5555;
    @(negedge iCLK);
    check({tag, "_arv"}, m_ARVALID, 1);
    check({tag, "_araddr"}, m_ARADDR, a);
    @(negedge iCLK);
    check({tag, "_arv_off"}, m_ARVALID, 0);
    check({tag, "_rready"}, m_RREADY, 1);
    @(negedge iCLK);
    check({tag, "_done"}, read_done, 1);
    check({tag, "_rdata"}, read_data, d);
    check({tag, "_rresp"}, read_resp, rr);
    check({tag, "_rready_off"}, m_RREADY, 0);
    @(negedge iCLK);
    check({tag, "_done_off"}, read_done, 0);
    check({tag, "_rdata_hold"}, read_data, d);
    @(posedge iCLK); #1;
    slave_idle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awv"}, m_AWVALID, 0);
    check({tag, "_wv"}, m_WVALID, 0);
    check({tag, "_bready"}, m_BREADY, 0);
    check({tag, "_arv"}, m_ARVALID, 0);
    check({tag, "_rready"}, m_RREADY, 0);
    check({tag, "_araddr"}, m_ARADDR, 0);
    check({tag, "_awaddr"}, m_AWADDR, 0);
    check({tag, "_wdata"}, m_WDATA, 0);
    check({tag, "_wstrb"}, m_WSTRB, 0);
    check({tag, "_prot"}, {m_AWPROT, m_ARPROT}, 0);
    check({tag, "_wdone"}, write_done, 0);
    check({tag, "_rdone"}, read_done, 0);
    check({tag, "_resps"}, {write_resp, read_resp}, 0);
    check({tag, "_rdata"}, read_data, 0);
  endtask

  initial begin
    int ar0, rd0, wd0, aw0;
    iRST = 0;
    slave_idle();
    write_req = 0; write_addr = 0; write_data = 0; write_strb = 0;
    read_req = 0; read_addr = 0;
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    check_all_zero("rst");
    @(posedge iCLK); #1;
    iRST = 1;

    // Read with ARREADY one cycle late
    @(posedge iCLK); #1;
    read_req = 1; read_addr = 32'h0000_0004;
    @(posedge iCLK); #1;
    read_req = 0; read_addr = 32'h0000_0099;
    @(negedge iCLK);
    check("rd1_arv", m_ARVALID, 1);
    check("rd1_araddr", m_ARADDR, 32'h4);
    @(posedge iCLK); #1;
    m_ARREADY = 1;
    @(negedge iCLK);
    check("rd1_arv_hold", m_ARVALID, 1);
    check("rd1_rready_early", m_RREADY, 0);
    @(posedge iCLK); #1;
    m_ARREADY = 0; m_RVALID = 1; m_RDATA = 32'hDEADBEEF; m_RRESP = 2'b00;
    @(negedge iCLK);
    check("rd1_arv_off", m_ARVALID, 0);
    check("rd1_rready", m_RREADY, 1);
    @(posedge iCLK); #1;
    m_RVALID = 0; m_RDATA = 0;
    @(negedge iCLK);
    check("rd1_done", read_done, 1);
    check("rd1_rdata", read_data, 32'hDEADBEEF);
    check("rd1_rresp", read_resp, 0);
    check("rd1_rready_off", m_RREADY, 0);
    @(negedge iCLK);
    check("rd1_done_off", read_done, 0);
    check("rd1_ar_count", ar_cnt, 1);

    // Write, always-ready slave
    write_fast(32'h4, 32'hDEADBEEF, 4'hF, 2'b00, "wr1");

    // Skewed write handshake: AWREADY cycle 1, WREADY cycle 4, BVALID cycle 6
    wd0 = wd_cnt; aw0 = aw_cnt;
    @(posedge iCLK); #1;
    write_req = 1; write_addr = 32'h10; write_data = 32'h1234_5678; write_strb = 4'h3;
    for (int c = 1; c <= 8; c++) begin
      @(posedge iCLK); #1;
      write_req = 0;
      m_AWREADY = (c == 1);
      m_WREADY  = (c == 4);
      m_BVALID  = (c == 6);
      m_BRESP   = 2'b01;
      @(negedge iCLK);
      check($sformatf("skew_awv_c%0d", c), m_AWVALID, (c == 1));
      check($sformatf("skew_wv_c%0d", c), m_WVALID, (c <= 4));
      check($sformatf("skew_bready_c%0d", c), m_BREADY, (c == 5 || c == 6));
      check($sformatf("skew_done_c%0d", c), write_done, (c == 7));
    end
    check("skew_done_count", wd_cnt - wd0, 1);
    check("skew_aw_count", aw_cnt - aw0, 1);
    check("skew_resp", write_resp, 2'b01);
    slave_idle();

    // Error responses
    write_fast(32'h240, 32'h0456_0FED, 4'hF, 2'b10, "wr_err");
    read_fast(32'h244, 32'hA5A5_1234, 2'b11, "rd_err");

    // Held read request: only one AR
    ar0 = ar_cnt; rd0 = rd_cnt;
    @(posedge iCLK); #1;
    m_ARREADY = 1; m_RVALID = 1; m_RDATA = 32'h0BAD_F00D; m_RRESP = 0;
    read_req = 1; read_addr = 32'h8;
    repeat (10) @(posedge iCLK);
    #1;
    read_req = 0;
    slave_idle();
    @(negedge iCLK);
    check("held_ar_count", ar_cnt - ar0, 1);
    check("held_done_count", rd_cnt - rd0, 1);
    check("held_rdata", read_data, 32'h0BAD_F00D);

    // Simultaneous write and read
    ar0 = ar_cnt; rd0 = rd_cnt; wd0 = wd_cnt;
    @(posedge iCLK); #1;
    m_AWREADY = 1; m_WREADY = 1; m_BVALID = 1; m_BRESP = 2'b01;
    m_ARREADY = 1; m_RVALID = 1; m_RDATA = 32'hCAFE_F00D; m_RRESP = 2'b00;
    write_req = 1; write_addr = 32'h20; write_data = 32'h1111_2222; write_strb = 4'hC;
    read_req = 1; read_addr = 32'h30;
    @(posedge iCLK); #1;
    write_req = 0; read_req = 0;
    @(negedge iCLK);
    check("conc_awaddr", m_AWADDR, 32'h20);
    check("conc_araddr", m_ARADDR, 32'h30);
    @(negedge iCLK);
    @(negedge iCLK);
    check("conc_wdone", write_done, 1);
    check("conc_rdone", read_done, 1);
    check("conc_wresp", write_resp, 2'b01);
    check("conc_rdata", read_data, 32'hCAFE_F00D);
    repeat (3) @(negedge iCLK);
    check("conc_wd_count", wd_cnt - wd0, 1);
    check("conc_rd_count", rd_cnt - rd0, 1);
    slave_idle();

    // Reset while ARVALID is high
    rd0 = rd_cnt;
    @(posedge iCLK); #1;
    read_req = 1; read_addr = 32'h77;
    @(posedge iCLK); #1;
    read_req = 0;
    @(negedge iCLK);
    check("mid_arv", m_ARVALID, 1);
    #2;
    iRST = 0;
    #1;
    check_all_zero("mid_rst");
    repeat (2) @(posedge iCLK);
    #1;
    iRST = 1;
    repeat (4) @(negedge iCLK);
    check("mid_no_done", rd_cnt - rd0, 0);
    check("mid_arv_idle", m_ARVALID, 0);
    read_fast(32'h8, 32'h600D_DA7A, 2'b00, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
